// File: rtl/data_chk_axi_mm_burst_if.sv
// AXI4 read-channel bundle (AR + R) used by the burst data checker.
`timescale 1ns/1ps
interface data_chk_axi_mm_burst_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output araddr, arprot, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arprot, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/data_chk_axi_mm_burst.sv
// AXI4 burst read master that reads a buffer back and checks every beat
// against the deterministic byte pattern (8'h80 + beat index + byte lane).
`timescale 1ns/1ps
module data_chk_axi_mm_burst #(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned MAX_BURST_LEN  = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR,
    input  logic [15:0]               BYTES,
    input  logic [15:0]               REPEAT,
    input  logic                      START,
    output logic                      BUSY,
    output logic                      DONE,
    output logic [15:0]               ERR_COUNT,
    output logic                      ERR_FLAG,
    output logic [AXI_ADDR_WIDTH-1:0] FIRST_ERR_ADDR,
    data_chk_axi_mm_burst_if.master   m_axi
);

    localparam int unsigned BEAT_BYTES = AXI_DATA_WIDTH / 8;
    localparam logic [7:0]  LAST_BEAT  = 8'(MAX_BURST_LEN - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] BURST_STEP =
        AXI_ADDR_WIDTH'(MAX_BURST_LEN * BEAT_BYTES);
    localparam logic [16:0] BEAT_INC   = 17'(BEAT_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        AR_SEND,
        R_RECV,
        FINISH
    } state_t;

    state_t                    state;
    logic [AXI_ADDR_WIDTH-1:0] base_addr;
    logic [AXI_ADDR_WIDTH-1:0] cur_addr;
    logic [15:0]               bytes_total;
    logic [15:0]               repeat_total;
    logic [15:0]               pass_cnt;
    logic [16:0]               byte_cnt;
    logic [7:0]                k;
    logic [7:0]                beat_cnt;
    logic                      arvalid;
    logic                      rready;

    logic [AXI_DATA_WIDTH-1:0] exp_data;
    logic                      beat_last;
    logic                      beat_fire;
    logic                      beat_fail;
    logic                      pass_done;
    logic                      final_pass;
    logic [16:0]               bytes_next;
    logic [AXI_ADDR_WIDTH-1:0] beat_offset;

    assign m_axi.araddr  = cur_addr;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arlen   = LAST_BEAT;
    assign m_axi.arsize  = 3'($clog2(BEAT_BYTES));
    assign m_axi.arburst = 2'b01;
    assign m_axi.arvalid = arvalid;
    assign m_axi.rready  = rready;

    assign ERR_FLAG = (ERR_COUNT != '0);

    always_comb begin
        exp_data = '0;
        for (int unsigned i = 0; i < BEAT_BYTES; i++) begin
            exp_data[i*8 +: 8] = 8'h80 + k + 8'(i);
        end
    end

    // rready is only ever high in R_RECV, so this is the beat handshake.
    assign beat_fire   = rready && m_axi.rvalid;
    assign beat_last   = (beat_cnt == LAST_BEAT);
    assign beat_fail   = (m_axi.rdata != exp_data) ||
                         (m_axi.rresp != 2'b00) ||
                         (m_axi.rlast != beat_last);
    assign bytes_next  = byte_cnt + BEAT_INC;
    assign pass_done   = (bytes_next >= {1'b0, bytes_total});
    assign final_pass  = (pass_cnt == repeat_total - 16'd1);
    assign beat_offset = AXI_ADDR_WIDTH'(beat_cnt) * AXI_ADDR_WIDTH'(BEAT_BYTES);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state          <= IDLE;
            base_addr      <= '0;
            cur_addr       <= '0;
            bytes_total    <= '0;
            repeat_total   <= '0;
            pass_cnt       <= '0;
            byte_cnt       <= '0;
            k              <= '0;
            beat_cnt       <= '0;
            arvalid        <= 1'b0;
            rready         <= 1'b0;
            BUSY           <= 1'b0;
            DONE           <= 1'b0;
            ERR_COUNT      <= '0;
            FIRST_ERR_ADDR <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        base_addr      <= BASE_ADDR;
                        cur_addr       <= BASE_ADDR;
                        bytes_total    <= BYTES;
                        repeat_total   <= (REPEAT == '0) ? 16'd1 : REPEAT;
                        pass_cnt       <= '0;
                        byte_cnt       <= '0;
                        k              <= '0;
                        ERR_COUNT      <= '0;
                        FIRST_ERR_ADDR <= '0;
                        arvalid        <= 1'b1;
                        BUSY           <= 1'b1;
                        state          <= AR_SEND;
                    end
                end

                AR_SEND: begin
                    if (m_axi.arready) begin
                        arvalid  <= 1'b0;
                        rready   <= 1'b1;
                        beat_cnt <= '0;
                        state    <= R_RECV;
                    end
                end

                R_RECV: begin
                    if (beat_fire) begin
                        // ERR_COUNT==0 marks the first failure since START;
                        // saturation never brings it back to zero.
                        if (beat_fail) begin
                            if (ERR_COUNT == '0) begin
                                FIRST_ERR_ADDR <= cur_addr + beat_offset;
                            end
                            if (ERR_COUNT != '1) begin
                                ERR_COUNT <= ERR_COUNT + 16'd1;
                            end
                        end
                        k        <= k + 8'd1;
                        byte_cnt <= bytes_next;
                        beat_cnt <= beat_cnt + 8'd1;
                        // Burst length is set by our own beat counter; rlast
                        // is only checked, never trusted.
                        if (beat_last) begin
                            rready   <= 1'b0;
                            cur_addr <= cur_addr + BURST_STEP;
                            if (pass_done && final_pass) begin
                                DONE  <= 1'b1;
                                state <= FINISH;
                            end else if (pass_done) begin
                                cur_addr <= base_addr;
                                k        <= '0;
                                byte_cnt <= '0;
                                pass_cnt <= pass_cnt + 16'd1;
                                arvalid  <= 1'b1;
                                state    <= AR_SEND;
                            end else begin
                                arvalid <= 1'b1;
                                state   <= AR_SEND;
                            end
                        end
                    end
                end

                FINISH: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
